// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, slave state codes and burst helpers used by the
// SRAM slave and its burst address checker.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3,
    HSIZE_QWORD = 3'd4,
    HSIZE_OWORD = 3'd5,
    HSIZE_64B   = 3'd6,
    HSIZE_128B  = 3'd7
  } hsize_e;

  typedef enum logic [1:0] {
    SS_IDLE = 2'd0,
    SS_WAIT = 2'd1,
    SS_ERR1 = 2'd2,
    SS_ERR2 = 2'd3
  } slave_state_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Beats in a fixed-length burst; 0 means unbounded (INCR).
  function automatic logic [4:0] burst_beats(input logic [2:0] burst);
    logic [4:0] n;
    n = 5'd0;
    case (burst)
      HBURST_SINGLE:               n = 5'd1;
      HBURST_WRAP4, HBURST_INCR4:  n = 5'd4;
      HBURST_WRAP8, HBURST_INCR8:  n = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: n = 5'd16;
      default:                     n = 5'd0;
    endcase
    return n;
  endfunction

  function automatic logic burst_is_wrap(input logic [2:0] burst);
    return (burst == HBURST_WRAP4) || (burst == HBURST_WRAP8) || (burst == HBURST_WRAP16);
  endfunction

endpackage

// File: rtl/ahb_burst_addr_chk.sv
// Follows a burst from its NONSEQ beat and flags any SEQ beat whose address
// differs from the expected next address or that overruns a fixed-length burst.
module ahb_burst_addr_chk
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  accept,
  input  logic [1:0]            htrans,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  output logic                  seq_err
);

  logic [ADDR_WIDTH-1:0] exp_addr_q, exp_addr_d;
  logic [4:0]            beat_cnt_q, beat_cnt_d;
  logic [2:0]            burst_q, burst_d;
  logic [2:0]            size_q, size_d;

  logic                  is_seq;
  logic                  overrun;
  logic [2:0]            cur_burst;
  logic [2:0]            cur_size;
  logic [4:0]            beats;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] next_addr;

  always_comb begin
    is_seq    = (htrans == HTRANS_SEQ);
    cur_burst = is_seq ? burst_q : hburst;
    cur_size  = is_seq ? size_q : hsize;
    beats     = burst_beats(cur_burst);
    wrap_mask = (ADDR_WIDTH'(beats) << cur_size) - ADDR_WIDTH'(1);
    next_addr = haddr + (ADDR_WIDTH'(1) << cur_size);
    if (burst_is_wrap(cur_burst)) begin
      next_addr = (haddr & ~wrap_mask) | (next_addr & wrap_mask);
    end
    // A zero beat count means no burst is open, so any SEQ is out of place.
    overrun = (beat_cnt_q == 5'd0) || ((beats != 5'd0) && (beat_cnt_q >= beats));
    seq_err = accept && is_seq && (overrun || (haddr != exp_addr_q));

    exp_addr_d = exp_addr_q;
    beat_cnt_d = beat_cnt_q;
    burst_d    = burst_q;
    size_d     = size_q;
    if (accept) begin
      if (!is_seq) begin
        beat_cnt_d = 5'd1;
        burst_d    = hburst;
        size_d     = hsize;
        exp_addr_d = next_addr;
      end else if (seq_err) begin
        beat_cnt_d = 5'd0;
      end else begin
        if (beat_cnt_q != 5'h1f) beat_cnt_d = beat_cnt_q + 5'd1;
        exp_addr_d = next_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_addr_q <= '0;
      beat_cnt_q <= 5'd0;
      burst_q    <= 3'd0;
      size_q     <= 3'd0;
    end else begin
      exp_addr_q <= exp_addr_d;
      beat_cnt_q <= beat_cnt_d;
      burst_q    <= burst_d;
      size_q     <= size_d;
    end
  end

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave in front of a word-addressed storage array: byte-lane writes,
// programmable wait states, burst address checking and two-cycle ERROR response.
module ahb_lite_sram_slave
  import ahb_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          DATA_WIDTH  = 32,
  parameter int          DEPTH       = 1024,
  parameter logic [63:0] BASE_ADDR   = 64'd0,
  parameter int          WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic                  HMASTLOCK,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [1:0]            dbg_state
);

  localparam int          NB     = DATA_WIDTH / 8;
  localparam int          LANE_W = $clog2(NB);
  localparam int          IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] SPAN   = 64'(DEPTH) * 64'(NB);
  localparam logic [3:0]  WAITS  = 4'(WAIT_STATES);

  localparam logic [1:0] ST_IDLE = SS_IDLE;
  localparam logic [1:0] ST_WAIT = SS_WAIT;
  localparam logic [1:0] ST_ERR1 = SS_ERR1;
  localparam logic [1:0] ST_ERR2 = SS_ERR2;

  logic [1:0]            state_q, state_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic                  pend_q, pend_d;
  logic                  write_q, write_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [LANE_W-1:0]     lane_q, lane_d;
  logic [2:0]            size_q, size_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  ready;
  logic                  accept;
  logic                  seq_err;
  logic [63:0]           addr64;
  logic [63:0]           off64;
  logic [7:0]            size_bytes;
  logic                  phase_err;
  logic [IDX_W-1:0]      acc_idx;
  logic                  wr_en;
  logic                  lane_on;
  logic [DATA_WIDTH-1:0] wr_word;
  logic                  unused_ok;

  assign unused_ok = ^{HPROT, HMASTLOCK};

  ahb_burst_addr_chk #(.ADDR_WIDTH(ADDR_WIDTH)) u_burst_chk (
    .clk     (HCLK),
    .rst     (HRESET),
    .accept  (accept),
    .htrans  (HTRANS),
    .haddr   (HADDR),
    .hsize   (HSIZE),
    .hburst  (HBURST),
    .seq_err (seq_err)
  );

  always_comb begin
    ready      = (state_q != ST_WAIT) && (state_q != ST_ERR1);
    accept     = HSEL && HREADY && HTRANS[1] && ready;
    addr64     = 64'(HADDR);
    off64      = addr64 - BASE_ADDR;
    size_bytes = 8'd1 << HSIZE;
    phase_err  = (addr64 < BASE_ADDR) || (off64 >= SPAN)
              || ((HADDR[7:0] & (size_bytes - 8'd1)) != 8'd0)
              || ((16'd8 << HSIZE) > 16'(DATA_WIDTH))
              || seq_err;
    acc_idx    = IDX_W'(off64 >> LANE_W);
    // The pending write lands at the end of its completing cycle (IDLE with a phase pending).
    wr_en      = (state_q == ST_IDLE) && pend_q && write_q;
    wr_word    = mem_q[idx_q];
    lane_on    = 1'b0;
    for (int i = 0; i < NB; i++) begin
      lane_on = (i >= int'(lane_q)) && (i < int'(lane_q) + (1 << size_q));
      if (lane_on) wr_word[8*i +: 8] = HWDATA[8*i +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    pend_d     = pend_q;
    write_d    = write_q;
    idx_d      = idx_q;
    lane_d     = lane_q;
    size_d     = size_q;
    rdata_d    = rdata_q;
    case (state_q)
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q - 4'd1;
        if (wait_cnt_q == 4'd1) begin
          state_d = ST_IDLE;
          if (!write_q) rdata_d = mem_q[idx_q];
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        state_d = ST_IDLE;
        pend_d  = 1'b0;
        if (accept) begin
          if (phase_err) begin
            state_d = ST_ERR1;
          end else begin
            pend_d  = 1'b1;
            write_d = HWRITE;
            idx_d   = acc_idx;
            lane_d  = HADDR[LANE_W-1:0];
            size_d  = HSIZE;
            if (WAITS != 4'd0) begin
              state_d    = ST_WAIT;
              wait_cnt_d = WAITS;
            end else if (!HWRITE) begin
              // Forward a write committing on this same edge so read-after-write sees new data.
              rdata_d = (wr_en && (idx_q == acc_idx)) ? wr_word : mem_q[acc_idx];
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 4'd0;
      pend_q     <= 1'b0;
      write_q    <= 1'b0;
      idx_q      <= '0;
      lane_q     <= '0;
      size_q     <= 3'd0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      pend_q     <= pend_d;
      write_q    <= write_d;
      idx_q      <= idx_d;
      lane_q     <= lane_d;
      size_q     <= size_d;
      rdata_q    <= rdata_d;
    end
  end

  // Storage keeps its contents across reset; only an in-flight write is dropped.
  always_ff @(posedge HCLK) begin
    if (!HRESET && wr_en) mem_q[idx_q] <= wr_word;
  end

  assign HREADYOUT = ready;
  assign HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA    = rdata_q;
  assign dbg_state = state_q;

endmodule

// File: doc/ahb_lite_sram_slave.md
# ahb_lite_sram_slave

Parametrised AHB-Lite slave that fronts an on-chip word-addressed storage array: sits behind the AHB decoder (one HSEL per instance) and serves single and burst transfers with configurable wait states. Supersedes the fixed-width interface bundle with real slave behaviour: byte-lane writes from HSIZE/HADDR, programmable wait states, burst-sequence address checking and the two-cycle AHB ERROR response.

## Interface
- ADDR_WIDTH, 32, HADDR width
- DATA_WIDTH, 32, HWDATA/HRDATA width; legal 32, 64, 128
- DEPTH, 1024, storage words of DATA_WIDTH bits
- BASE_ADDR, 0, byte address of word 0; aligned to DEPTH*DATA_WIDTH/8
- WAIT_STATES, 0, HREADYOUT-low cycles per OKAY transfer, 0..15
- HCLK  in  1  clock; all logic on rising edge
- HRESET  in  1  synchronous, active-high reset
- HSEL  in  1  slave select from decoder
- HADDR  in  ADDR_WIDTH  byte address
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- HWRITE  in  1  1=write
- HSIZE  in  3  bytes = 2^HSIZE
- HBURST  in  3  SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16
- HPROT  in  4  accepted, ignored
- HMASTLOCK  in  1  accepted, ignored
- HWDATA  in  DATA_WIDTH  write data (data phase)
- HREADY  in  1  bus ready (address-phase qualifier)
- HRDATA  out  DATA_WIDTH  read data, valid when HREADYOUT=1 on a read data phase
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0=OKAY, 1=ERROR

## Operation
- Address phase accepted when HSEL && HREADY && HTRANS[1]; HADDR, HWRITE, HSIZE, HBURST registered. IDLE/BUSY or HSEL=0: zero-wait OKAY, no storage access.
- Error checks on accepted phase (any → ERROR, no storage access): address outside [BASE_ADDR, BASE_ADDR+DEPTH*DATA_WIDTH/8); HADDR not aligned to 2^HSIZE; 8*2^HSIZE > DATA_WIDTH; SEQ whose HADDR ≠ expected next burst address.
- Expected address: previous + 2^HSIZE; WRAP bursts wrap inside a (beats*2^HSIZE)-byte aligned block; beat counter from NONSEQ; SEQ after final beat of fixed-length burst → ERROR. INCR unbounded.
- Writes: only lanes [HADDR mod (DATA_WIDTH/8)] .. +2^HSIZE-1 updated from HWDATA; commit at end of final data-phase cycle.
- Reads: whole word at registered index driven on HRDATA; byte selection is master's.
- States: IDLE → (OKAY, WAIT_STATES>0) WAIT → IDLE after WAIT_STATES cycles; IDLE → (OKAY, 0 waits) completes in place; any → (error) ERR1 → ERR2 → IDLE/next.
- ERR1: HREADYOUT=0, HRESP=1. ERR2: HREADYOUT=1, HRESP=1; new address phase accepted in ERR2 (master may cancel by driving IDLE).
- Reset: HREADYOUT=1, HRESP=0, HRDATA=0, state IDLE, beat counter 0, no pending phase; storage not cleared. HRESET mid-transfer discards pending write.

## Timing
- Address phase cycle N; data phase N+1; completes N+1+WAIT_STATES (OKAY) or N+2 (ERROR).
- Write followed by read to same word: read returns new data (write commits before read data phase samples).
- Pipelined address phase during WAIT held by master (HREADY=0) and accepted only on completing cycle.
- HRDATA held between transfers; driven 0 only on reset.

## Structure
- Package ahb_pkg: htrans_e, hburst_e, hsize_e, slave state enum, burst beat-count function, OKAY/ERROR constants.
- Sub-module ahb_burst_addr_chk: tracks beat count and expected next address, flags SEQ mismatch/overrun.

## Test plan
- Reset: HRESET=1 two cycles → HREADYOUT=1, HRESP=0, HRDATA=0.
- WAIT_STATES=0, write 0xDEADBEEF to 0x10 (HSIZE=2) then read 0x10 → read data phase one cycle, HRDATA=0xDEADBEEF, HRESP=0.
- Byte write 0xAA to 0x13 (HSIZE=0) over 0x11223344 → read returns 0xAA223344.
- WAIT_STATES=3, INCR4 read from 0x20 → each beat 3 cycles HREADYOUT=0 then 1; four words in order.
- WRAP4 from 0x38: beats 0x38,0x3C,0x30,0x34 → OKAY; SEQ to 0x40 instead of 0x30 → ERR1 then ERR2.
- Read at BASE_ADDR+4096 (DEPTH=1024), and HSIZE=3 with DATA_WIDTH=32 → HREADYOUT 0,1 with HRESP 1,1; storage unchanged.
